dpram_be_sweep: RTL

//  Parametrised true dual-port RAM (ports A and B) on a single clock, with per-byte write

---
 rtl/dpram_be_sweep_if.sv | 36 +++
 rtl/dpram_be_sweep.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dpram_be_sweep_if.sv
// Port bundle for dpram_be_sweep: both RAM ports, the clear-engine handshake and the collision flag.
// The bench drives the master side and the RAM sits on the slave side.
interface dpram_be_sweep_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 7
);
    localparam int BE_W = DATA_W / 8;

    logic              init_req;
    logic              init_busy;
    logic              cea;
    logic              ceb;
    logic              wrea;
    logic              wreb;
    logic [BE_W-1:0]   bea;
    logic [BE_W-1:0]   beb;
    logic [ADDR_W-1:0] ada;
    logic [ADDR_W-1:0] adb;
    logic [DATA_W-1:0] dina;
    logic [DATA_W-1:0] dinb;
    logic              ocea;
    logic              oceb;
    logic [DATA_W-1:0] douta;
    logic [DATA_W-1:0] doutb;
    logic              collision;

    modport master (
        output init_req, cea, ceb, wrea, wreb, bea, beb, ada, adb, dina, dinb, ocea, oceb,
        input  init_busy, douta, doutb, collision
    );

    modport slave (
        input  init_req, cea, ceb, wrea, wreb, bea, beb, ada, adb, dina, dinb, ocea, oceb,
        output init_busy, douta, doutb, collision
    );
endinterface

// File: rtl/dpram_be_sweep.sv
// True dual-port byte-enable RAM on one clock with selectable write mode, optional output
// register, A/B collision flag and a clear engine that fills the array with INIT_VALUE.
module dpram_be_sweep #(
    parameter int              DATA_W         = 16,
    parameter int              ADDR_W         = 7,
    parameter int              READ_REG       = 0,
    parameter int              WRITE_MODE     = 0,
    parameter int              CLEAR_ON_RESET = 1,
    parameter logic [DATA_W-1:0] INIT_VALUE   = '0
) (
    input  logic            clk,
    input  logic            resetn,
    dpram_be_sweep_if.slave bus
);
    localparam int         BE_W     = DATA_W / 8;
    localparam int         DEPTH    = 2 ** ADDR_W;
    localparam bit         RD_PIPE  = (READ_REG != 32'sd0);
    localparam bit         CLR_RST  = (CLEAR_ON_RESET != 32'sd0);
    localparam logic [1:0] WM       = 2'(WRITE_MODE);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    // Replace every enabled byte of old_w with the matching byte of new_w.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < BE_W; i++) begin
            res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

    // Stage-1 next value: reads take the pre-edge word, writes follow the write mode.
    function automatic logic [DATA_W-1:0] stage_next(
        input logic              act,
        input logic              wr,
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] fin_w,
        input logic [DATA_W-1:0] hold_w
    );
        logic [DATA_W-1:0] res;
        res = hold_w;
        if (act && !wr) begin
            res = old_w;
        end else if (act && wr) begin
            case (WM)
                2'd1:    res = fin_w;
                2'd2:    res = old_w;
                default: res = hold_w;
            endcase
        end else begin
            res = hold_w;
        end
        return res;
    endfunction

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                act_a_s, act_b_s, we_a_s, we_b_s, same_s;
    logic [DATA_W-1:0]   old_a_s, old_b_s, fin_a_s, fin_b_s;
    logic [DATA_W-1:0]   s1a_q, s1a_d, s1b_q, s1b_d;
    logic [DATA_W-1:0]   pa_q, pa_d, pb_q, pb_d;
    logic                coll_q, coll_d;

    // Port qualification: a running sweep masks both ports.
    assign act_a_s = bus.cea & ~busy_q;
    assign act_b_s = bus.ceb & ~busy_q;
    assign we_a_s  = act_a_s & bus.wrea;
    assign we_b_s  = act_b_s & bus.wreb;
    assign same_s  = (bus.ada == bus.adb);
    assign old_a_s = mem_q[bus.ada];
    assign old_b_s = mem_q[bus.adb];

    // On a shared address port B is merged first so port A wins every byte it enables.
    assign fin_a_s = merge_bytes(merge_bytes(old_a_s, bus.dinb, bus.beb & {BE_W{we_b_s & same_s}}),
                                 bus.dina, bus.bea & {BE_W{we_a_s}});
    assign fin_b_s = merge_bytes(merge_bytes(old_b_s, bus.dinb, bus.beb & {BE_W{we_b_s}}),
                                 bus.dina, bus.bea & {BE_W{we_a_s & same_s}});

    // Clear-engine next state and sweep address.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.init_req) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                clr_addr_d = clr_addr_q + ADDR_W'(1);
                if (clr_addr_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                clr_addr_d = '0;
            end
        endcase
        busy_d = (state_d == ST_CLEAR);
    end

    // Clear-engine state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= CLR_RST ? ST_CLEAR : ST_IDLE;
            clr_addr_q <= '0;
            busy_q     <= CLR_RST;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            busy_q     <= busy_d;
        end
    end

    // Storage array: not reset; the sweep owns it while busy, otherwise both ports write.
    always_ff @(posedge clk) begin
        if (resetn) begin
            if (busy_q) begin
                mem_q[clr_addr_q] <= INIT_VALUE;
            end else begin
                if (we_b_s) begin
                    mem_q[bus.adb] <= fin_b_s;
                end
                if (we_a_s) begin
                    mem_q[bus.ada] <= fin_a_s;
                end
            end
        end
    end

    // Read stage, output pipeline and collision next values.
    always_comb begin
        s1a_d  = stage_next(act_a_s, bus.wrea, old_a_s, fin_a_s, s1a_q);
        s1b_d  = stage_next(act_b_s, bus.wreb, old_b_s, fin_b_s, s1b_q);
        pa_d   = pa_q;
        pb_d   = pb_q;
        if (RD_PIPE && !busy_q && bus.ocea) begin
            pa_d = s1a_q;
        end else begin
            pa_d = pa_q;
        end
        if (RD_PIPE && !busy_q && bus.oceb) begin
            pb_d = s1b_q;
        end else begin
            pb_d = pb_q;
        end
        coll_d = act_a_s & act_b_s & same_s & (we_a_s | we_b_s);
    end

    // Read-path and collision registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1a_q  <= '0;
            s1b_q  <= '0;
            pa_q   <= '0;
            pb_q   <= '0;
            coll_q <= 1'b0;
        end else begin
            s1a_q  <= s1a_d;
            s1b_q  <= s1b_d;
            pa_q   <= pa_d;
            pb_q   <= pb_d;
            coll_q <= coll_d;
        end
    end

    assign bus.douta     = RD_PIPE ? pa_q : s1a_q;
    assign bus.doutb     = RD_PIPE ? pb_q : s1b_q;
    assign bus.collision = coll_q;
    assign bus.init_busy = busy_q;

endmodule
